// File: rtl/match_ctrl.sv
// Rally/match sequencer for the pika-ball game: floor-touch detection, point award,
// win-by-N / score-cap match end, pause/freeze, serve-side tracking and abort-to-idle.
module match_ctrl #(
    parameter int unsigned COORD_W       = 12,
    parameter int unsigned SCORE_W       = 4,
    parameter int unsigned POINTS_TO_WIN = 7,
    parameter int unsigned WIN_BY        = 1,
    parameter int unsigned SCORE_CAP     = 15,
    parameter int unsigned COURT_MID     = 160,
    parameter int unsigned FLOOR_Y       = 220,
    parameter int unsigned BALL_H        = 30,
    parameter int unsigned START_CYCLES  = 100_000_000,
    parameter int unsigned SERVE_CYCLES  = 50_000_000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run_n,
    input  logic               pause_req,
    input  logic [COORD_W-1:0] ball_x,
    input  logic [COORD_W-1:0] ball_y,
    output logic [1:0]         game_state,
    output logic               freeze,
    output logic [SCORE_W-1:0] player_score,
    output logic [SCORE_W-1:0] npc_score,
    output logic               point_pulse,
    output logic               point_winner,
    output logic               serve_side,
    output logic               match_winner
);

    localparam int unsigned MAX_CYCLES = (START_CYCLES > SERVE_CYCLES) ? START_CYCLES : SERVE_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);
    localparam int unsigned EXT_W      = COORD_W + 1;

    localparam logic [TIMER_W-1:0] START_LAST = TIMER_W'(START_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_CYCLES - 1);
    localparam logic [EXT_W-1:0]   BALL_H_EXT = EXT_W'(BALL_H);
    localparam logic [EXT_W-1:0]   FLOOR_EXT  = EXT_W'(FLOOR_Y);
    localparam logic [COORD_W-1:0] MID_X      = COORD_W'(COURT_MID);
    localparam logic [SCORE_W-1:0] TO_WIN     = SCORE_W'(POINTS_TO_WIN);
    localparam logic [SCORE_W-1:0] LEAD_MIN   = SCORE_W'(WIN_BY);
    localparam logic [SCORE_W-1:0] CAP        = SCORE_W'(SCORE_CAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SERVE,
        S_PLAY,
        S_SCORE,
        S_CHECK,
        S_PAUSE,
        S_END
    } state_t;

    state_t               state, state_next;
    state_t               saved_state, saved_next;
    logic [TIMER_W-1:0]   timer, timer_next;

    logic [EXT_W-1:0]     ball_bottom_c;
    logic                 touch_c;
    logic                 award_npc_c;
    logic [SCORE_W-1:0]   player_lead_c;
    logic [SCORE_W-1:0]   npc_lead_c;
    logic                 player_win_c;
    logic                 npc_win_c;

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            S_SERVE:                  state_code = 2'd1;
            S_PLAY, S_SCORE, S_CHECK: state_code = 2'd2;
            S_END:                    state_code = 2'd3;
            default:                  state_code = 2'd0;
        endcase
    endfunction

    // Extra bit keeps ball_y + BALL_H from wrapping near the top of the coordinate range.
    assign ball_bottom_c = {1'b0, ball_y} + BALL_H_EXT;
    assign touch_c       = (ball_bottom_c >= FLOOR_EXT);
    assign award_npc_c   = (ball_x >= MID_X);

    // Win evaluation on the registered (already updated) scores.
    assign player_lead_c = (player_score > npc_score) ? (player_score - npc_score) : '0;
    assign npc_lead_c    = (npc_score > player_score) ? (npc_score - player_score) : '0;
    assign player_win_c  = ((player_score >= TO_WIN) && (player_lead_c >= LEAD_MIN)) ||
                           (player_score == CAP);
    assign npc_win_c     = ((npc_score >= TO_WIN) && (npc_lead_c >= LEAD_MIN)) ||
                           (npc_score == CAP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            saved_state <= S_IDLE;
            timer       <= '0;
        end else begin
            state       <= state_next;
            saved_state <= saved_next;
            timer       <= timer_next;
        end
    end

    // Next-state logic; abort beats every other transition.
    always_comb begin
        state_next = state;
        saved_next = saved_state;
        timer_next = timer;
        if ((state != S_IDLE) && run_n) begin
            state_next = S_IDLE;
            timer_next = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!run_n) begin
                        state_next = S_START;
                        timer_next = '0;
                    end
                end
                S_START: begin
                    if (timer == START_LAST) begin
                        state_next = S_SERVE;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TIMER_W'(1);
                    end
                end
                S_SERVE: begin
                    // Serve expiry wins over a pause request in the same cycle.
                    if (timer == SERVE_LAST) begin
                        state_next = S_PLAY;
                        timer_next = '0;
                    end else begin
                        timer_next = timer + TIMER_W'(1);
                        if (pause_req) begin
                            state_next = S_PAUSE;
                            saved_next = S_SERVE;
                        end
                    end
                end
                S_PLAY: begin
                    if (touch_c) begin
                        state_next = S_SCORE;
                        timer_next = '0;
                    end else if (pause_req) begin
                        state_next = S_PAUSE;
                        saved_next = S_PLAY;
                    end
                end
                S_SCORE: begin
                    state_next = S_CHECK;
                    timer_next = '0;
                end
                S_CHECK: begin
                    state_next = (player_win_c || npc_win_c) ? S_END : S_SERVE;
                    timer_next = '0;
                end
                S_PAUSE: begin
                    if (pause_req) begin
                        state_next = saved_state;
                    end
                end
                S_END: begin
                    state_next = S_END;
                end
                default: begin
                    state_next = S_IDLE;
                    timer_next = '0;
                end
            endcase
        end
    end

    // Registered outputs; strobes and flags line up with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            game_state   <= 2'd0;
            freeze       <= 1'b0;
            player_score <= '0;
            npc_score    <= '0;
            point_pulse  <= 1'b0;
            point_winner <= 1'b0;
            serve_side   <= 1'b0;
            match_winner <= 1'b0;
        end else begin
            point_pulse <= (state_next == S_SCORE);
            freeze      <= (state_next == S_PAUSE);
            if (state != S_PAUSE) begin
                game_state <= state_code(state);
            end
            if ((state == S_IDLE) || (state_next == S_IDLE)) begin
                player_score <= '0;
                npc_score    <= '0;
                point_winner <= 1'b0;
                serve_side   <= 1'b0;
                match_winner <= 1'b0;
            end else begin
                if (state_next == S_SCORE) begin
                    point_winner <= award_npc_c;
                    serve_side   <= award_npc_c;
                    if (award_npc_c) begin
                        if (npc_score < CAP) begin
                            npc_score <= npc_score + SCORE_W'(1);
                        end
                    end else begin
                        if (player_score < CAP) begin
                            player_score <= player_score + SCORE_W'(1);
                        end
                    end
                end
                if ((state == S_CHECK) && (state_next == S_END)) begin
                    match_winner <= !player_win_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_match_ctrl.sv
// Self-checking bench for match_ctrl: directed scenarios plus random play, all
// compared cycle by cycle against a phase/countdown reference model.
module tb_match_ctrl;

    localparam int COORD_W   = 12;
    localparam int SCORE_W   = 4;
    localparam int PTW       = 3;
    localparam int WIN_BY    = 2;
    localparam int CAP       = 6;
    localparam int MID       = 160;
    localparam int FLOOR     = 220;
    localparam int BH        = 30;
    localparam int START_CYC = 4;
    localparam int SERVE_CYC = 3;

    localparam int P_IDLE  = 0;
    localparam int P_START = 1;
    localparam int P_SERVE = 2;
    localparam int P_PLAY  = 3;
    localparam int P_SCORE = 4;
    localparam int P_CHECK = 5;
    localparam int P_PAUSE = 6;
    localparam int P_END   = 7;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               run_n;
    logic               pause_req;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic [1:0]         game_state;
    logic               freeze;
    logic [SCORE_W-1:0] player_score;
    logic [SCORE_W-1:0] npc_score;
    logic               point_pulse;
    logic               point_winner;
    logic               serve_side;
    logic               match_winner;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: current phase, cycles remaining in a timed phase, visible outputs.
    int m_phase, m_left, m_saved;
    int m_gs, m_freeze, m_ps, m_ns, m_pulse, m_pw, m_serve, m_mw;

    match_ctrl #(
        .COORD_W(COORD_W), .SCORE_W(SCORE_W), .POINTS_TO_WIN(PTW), .WIN_BY(WIN_BY),
        .SCORE_CAP(CAP), .COURT_MID(MID), .FLOOR_Y(FLOOR), .BALL_H(BH),
        .START_CYCLES(START_CYC), .SERVE_CYCLES(SERVE_CYC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .run_n(run_n), .pause_req(pause_req),
        .ball_x(ball_x), .ball_y(ball_y), .game_state(game_state), .freeze(freeze),
        .player_score(player_score), .npc_score(npc_score), .point_pulse(point_pulse),
        .point_winner(point_winner), .serve_side(serve_side), .match_winner(match_winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int phase_code(input int p);
        if (p == P_SERVE) return 1;
        if (p == P_PLAY || p == P_SCORE || p == P_CHECK) return 2;
        if (p == P_END) return 3;
        return 0;
    endfunction

    function automatic bit wins(input int a, input int b);
        return ((a >= PTW) && (a - b >= WIN_BY)) || (a == CAP);
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE; m_left = 0; m_saved = P_IDLE;
        m_gs = 0; m_freeze = 0; m_ps = 0; m_ns = 0;
        m_pulse = 0; m_pw = 0; m_serve = 0; m_mw = 0;
    endtask

    // Advance the model across one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int  prev;
        bit  touch;
        prev  = m_phase;
        touch = (int'(ball_y) + BH) >= FLOOR;
        if (m_phase != P_IDLE && run_n) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE:  if (!run_n) begin m_phase = P_START; m_left = START_CYC; end
                P_START: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = P_SERVE; m_left = SERVE_CYC; end
                end
                P_SERVE: begin
                    m_left--;
                    if (m_left == 0) m_phase = P_PLAY;
                    else if (pause_req) begin m_saved = P_SERVE; m_phase = P_PAUSE; end
                end
                P_PLAY: begin
                    if (touch) begin
                        m_phase = P_SCORE;
                        m_pw    = (int'(ball_x) >= MID) ? 1 : 0;
                        m_serve = m_pw;
                        if (m_pw == 1) m_ns = (m_ns + 1 > CAP) ? CAP : m_ns + 1;
                        else           m_ps = (m_ps + 1 > CAP) ? CAP : m_ps + 1;
                    end else if (pause_req) begin
                        m_saved = P_PLAY; m_phase = P_PAUSE;
                    end
                end
                P_SCORE: m_phase = P_CHECK;
                P_CHECK: begin
                    if (wins(m_ps, m_ns))      begin m_phase = P_END; m_mw = 0; end
                    else if (wins(m_ns, m_ps)) begin m_phase = P_END; m_mw = 1; end
                    else begin m_phase = P_SERVE; m_left = SERVE_CYC; end
                end
                P_PAUSE: if (pause_req) m_phase = m_saved;
                default: ;
            endcase
        end
        if (prev != P_PAUSE) m_gs = phase_code(prev);
        m_freeze = (m_phase == P_PAUSE) ? 1 : 0;
        m_pulse  = (m_phase == P_SCORE) ? 1 : 0;
        if (m_phase == P_IDLE || prev == P_IDLE) begin
            m_ps = 0; m_ns = 0; m_pw = 0; m_serve = 0; m_mw = 0;
        end
    endtask

    task automatic compare_all();
        check("game_state",   32'(game_state),   32'(m_gs));
        check("freeze",       32'(freeze),       32'(m_freeze));
        check("player_score", 32'(player_score), 32'(m_ps));
        check("npc_score",    32'(npc_score),    32'(m_ns));
        check("point_pulse",  32'(point_pulse),  32'(m_pulse));
        check("point_winner", 32'(point_winner), 32'(m_pw));
        check("serve_side",   32'(serve_side),   32'(m_serve));
        check("match_winner", 32'(match_winner), 32'(m_mw));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (m_phase != p && n < budget) begin
            step();
            n++;
        end
        if (m_phase != p) check("wait_timeout", 32'(m_phase), 32'(p));
    endtask

    task automatic score_point(input bit npc);
        wait_phase(P_PLAY, 40);
        ball_x = npc ? 12'd200 : 12'd40;
        ball_y = 12'd190;
        step();
        ball_y = 12'd0;
        step();
        step();
    endtask

    task automatic restart();
        run_n = 1'b1;
        step();
        run_n = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; run_n = 1'b1; pause_req = 1'b0;
        ball_x = '0; ball_y = '0;
        model_reset();
        #3;
        compare_all();
        #10 reset_n = 1'b1;
        #1;

        // Start-up phase timing, game_state lags the state by one cycle.
        run_n = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("gs_seq", 32'(game_state), (k <= 5) ? 32'd0 : (k <= 8) ? 32'd1 : 32'd2);
        end

        // NPC-side floor touch.
        ball_x = 12'd200; ball_y = 12'd190;
        step();
        check("t2_pulse", 32'(point_pulse), 32'd1);
        check("t2_npc", 32'(npc_score), 32'd1);
        check("t2_pw", 32'(point_winner), 32'd1);
        check("t2_serve", 32'(serve_side), 32'd1);
        ball_y = 12'd0;
        step(); step(); step();
        check("t2_serve_gs", 32'(game_state), 32'd1);

        // Win-by-2 then cap.
        score_point(1'b1);
        score_point(1'b0); score_point(1'b0); score_point(1'b0);
        check("t3_ps", 32'(player_score), 32'd3);
        check("t3_ns", 32'(npc_score), 32'd2);
        check("t3_noend", 32'(m_phase == P_SERVE), 32'(game_state != 2'd3));
        score_point(1'b0);
        step();
        check("t3_gs_end", 32'(game_state), 32'd3);
        check("t3_mw", 32'(match_winner), 32'd0);
        restart();
        for (int i = 0; i < 11; i++) score_point(i[0]);
        step();
        check("t3_cap_ps", 32'(player_score), 32'd6);
        check("t3_cap_ns", 32'(npc_score), 32'd5);
        check("t3_cap_gs", 32'(game_state), 32'd3);
        restart();

        // Pause and resume during SERVE.
        wait_phase(P_SERVE, 20);
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_freeze", 32'(freeze), 32'd1);
            check("t4_gs_hold", 32'(game_state), 32'd1);
        end
        pause_req = 1'b1;
        step();
        pause_req = 1'b0;
        check("t4_unfreeze", 32'(freeze), 32'd0);
        step(); check("t4_serve1", 32'(game_state), 32'd1);
        step(); check("t4_serve2", 32'(game_state), 32'd1);
        step(); check("t4_play", 32'(game_state), 32'd2);

        // Pause and touch together: touch wins.
        ball_x = 12'd10; ball_y = 12'd200; pause_req = 1'b1;
        step();
        pause_req = 1'b0; ball_y = 12'd0;
        check("t5_pulse", 32'(point_pulse), 32'd1);
        check("t5_freeze", 32'(freeze), 32'd0);

        // Abort mid-PLAY.
        wait_phase(P_PLAY, 20);
        run_n = 1'b1;
        step();
        check("t6_ps_clr", 32'(player_score), 32'd0);
        run_n = 1'b0;
        // Async reset mid-SERVE.
        wait_phase(P_SERVE, 20);
        step();
        #2 reset_n = 1'b0;
        model_reset();
        #1 compare_all();
        #2 reset_n = 1'b1;

        // Random play.
        for (int i = 0; i < 1500; i++) begin
            run_n     = ($urandom_range(0, 99) < 2);
            pause_req = ($urandom_range(0, 99) < 6);
            ball_x    = 12'($urandom_range(0, 319));
            ball_y    = 12'($urandom_range(0, 240));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
